seg_display: RTL and testbench
==============================

SEG_DISPLAY -- requirements
Module: seg_display

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000: clock cycles per digit-scan step; legal range 2 or more.
REQ-002 SHALL have the port clock, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-003 SHALL have the port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have the port SegCtrl, input, 1 bit: chip select from the MemOrIO address decode.
REQ-005 SHALL have the port ioWrite, input, 1 bit: IO write strobe.
REQ-006 SHALL have the port write_data, input, 16 bits: IO write data.
REQ-007 SHALL have the port segAddr, input, 2 bits: low address bits. 00 = value[15:0], 10 = value[31:16], 01 = control, 11 = ignored.
REQ-008 SHALL have the port seg_out, output, 8 bits, active-low: bit0 = a … bit6 = g, bit7 = dp.
REQ-009 SHALL have the port seg_en, output, 8 bits, active-low: digit enables; bit0 is the least significant digit.
REQ-010 SHALL have the port busy, output, 1 bit: decimal conversion in progress.

Function
REQ-011 SHALL accept a write on any rising edge where SegCtrl=1 and ioWrite=1; no write SHALL occur otherwise.
REQ-012 SHALL define control register bits as: bit0 mode (0 hex, 1 decimal), bit1 blank_lz, bit2 disp_en; bits 15:3 are ignored.
REQ-013 SHALL, in hex mode, load the display shadow register from the value register one cycle after the write edge; busy stays 0.
REQ-014 SHALL, in decimal mode, start a double-dabble conversion on any value or control write; busy=1 from the next cycle for exactly 32 cycles.
REQ-015 SHALL update the shadow register with the 8 BCD digits on the same edge at which busy falls; the shadow SHALL NOT change mid-conversion.
REQ-016 SHALL restart a running conversion from the new value when a write arrives during it; busy stays 1 and the old result is discarded.
REQ-017 SHALL make all 8 shadow digits the dash pattern 8'hBF when the decimal value exceeds 99_999_999.
REQ-018 SHALL, when blank_lz=1, blank (8'hFF) every digit above the most significant nonzero digit; digit 0 is never blanked.
REQ-019 SHALL use a prescaler that counts 0..SCAN_DIV-1; at wrap the digit index advances 0→7 and wraps 7→0.
REQ-020 SHALL register seg_en and seg_out together: seg_en has one zero bit at the current index, and seg_out is that digit's pattern. dp is always 1.
REQ-021 SHALL use these hex patterns: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E.
REQ-022 SHALL drive seg_en=8'hFF while disp_en=0; scanning and conversion continue.
REQ-023 SHALL give precedence to the write when a write and a scan step occur on the same edge; the scan step still occurs.

Reset
REQ-024 SHALL clear on reset: value=0, control=3'b100, shadow=all '0' digits, prescaler=0, digit index=0, busy=0, and any conversion is aborted.
REQ-025 SHALL drive seg_out=8'hFF and seg_en=8'hFF from reset until the first prescaler wrap, which lights digit 0.
REQ-026 SHALL hold reset dominant over a simultaneous write.

Structure
REQ-027 SHALL place in shared package seg_pkg: the address constants for value-low, value-high and control; the control bit positions; the 16-entry pattern table; and the dash and blank constants.
REQ-028 SHALL implement the conversion as sub-module bin2bcd_seq (32-bit in, 10 BCD digits out, start/busy handshake, one shift per cycle).

Verification (SCAN_DIV=4)
REQ-029 SHALL cover: reset, write 16'h1234 @00 and 16'h0000 @10 → after the first wrap, seg_en=8'hFE and seg_out=8'h99; after the next wrap, seg_en=8'hFD and seg_out=8'hB0.
REQ-030 SHALL cover: control=3'b101, write 32'h00BC614E → busy high for 32 cycles; then digit0=8'h80 and digit7=8'hF9.
REQ-031 SHALL cover: decimal mode, write 32'h05F5E100 → all digits 8'hBF after busy falls.
REQ-032 SHALL cover: hex mode, blank_lz=1, value 32'h00000007 → digit0=8'hF8 and digits 1–7 seg_out=8'hFF.
REQ-033 SHALL cover: write at busy cycle 10, then reset at busy cycle 5 of the restarted conversion → first write's result never appears; after reset, busy=0, outputs 8'hFF, shadow all '0'.
REQ-034 SHALL cover: a write coincident with the prescaler wrap → the write is accepted and the digit index still advances.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment display controller: register map,
// control layout, segment patterns and the formatting helpers.
package seg_pkg;

   localparam logic [1:0] ADDR_VAL_LO  = 2'b00;
   localparam logic [1:0] ADDR_VAL_HI  = 2'b10;
   localparam logic [1:0] ADDR_CTRL    = 2'b01;
   localparam logic [1:0] ADDR_IGNORED = 2'b11;

   localparam int CTRL_MODE  = 0;
   localparam int CTRL_BLANK = 1;
   localparam int CTRL_DISP  = 2;

   typedef struct packed {
      logic disp_en;
      logic blank_lz;
      logic mode;
   } ctrl_t;

   localparam ctrl_t CTRL_RESET = 3'b100;

   localparam logic [7:0] SEG_DASH  = 8'hBF;
   localparam logic [7:0] SEG_BLANK = 8'hFF;
   localparam logic [7:0] SEG_ZERO  = 8'hC0;

   // Entry n is the active-low pattern for hex digit n (dp bit kept at 1).
   localparam logic [15:0][7:0] SEG_LUT = {
      8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
      8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
   };

   // One double-dabble iteration: add 3 to every BCD digit >= 5, then shift in a bit.
   function automatic logic [39:0] dd_step(input logic [39:0] bcd, input logic bit_in);
      logic [39:0] adj;
      adj = bcd;
      for (int i = 0; i < 10; i++) begin
         if (bcd[i*4 +: 4] >= 4'd5) begin
            adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
         end else begin
            adj[i*4 +: 4] = bcd[i*4 +: 4];
         end
      end
      return {adj[38:0], bit_in};
   endfunction

   // Eight nibbles to eight patterns; optional blanking above the leading nonzero digit.
   function automatic logic [7:0][7:0] fmt_digits(input logic [31:0] nibs, input logic blank_lz);
      logic [7:0][7:0] res;
      logic            seen;
      seen = 1'b0;
      for (int i = 7; i >= 0; i--) begin
         if (nibs[i*4 +: 4] != 4'd0) begin
            seen = 1'b1;
         end else begin
            seen = seen;
         end
         if (blank_lz && !seen && (i != 0)) begin
            res[i] = SEG_BLANK;
         end else begin
            res[i] = SEG_LUT[nibs[i*4 +: 4]];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 32-bit binary to 10-digit BCD converter, one double-dabble shift per
// clock; a start pulse always restarts from the presented operand.
module bin2bcd_seq
   import seg_pkg::*;
(
   input  logic        i_clock,
   input  logic        i_reset,
   input  logic        i_start,
   input  logic [31:0] i_bin,
   output logic        o_busy,
   output logic        o_last,
   output logic [39:0] o_bcd
);

   logic [31:0] r_sh;
   logic [39:0] r_bcd;
   logic [5:0]  r_cnt;
   logic        r_busy;

   // The first shift happens on the start edge, so 32 busy cycles end with a
   // complete result that the parent captures on the edge busy falls.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_sh   <= 32'd0;
         r_bcd  <= 40'd0;
         r_cnt  <= 6'd0;
         r_busy <= 1'b0;
      end else if (i_start) begin
         r_sh   <= {i_bin[30:0], 1'b0};
         r_bcd  <= dd_step(40'd0, i_bin[31]);
         r_cnt  <= 6'd1;
         r_busy <= 1'b1;
      end else if (r_busy) begin
         if (r_cnt == 6'd32) begin
            r_busy <= 1'b0;
         end else begin
            r_bcd <= dd_step(r_bcd, r_sh[31]);
            r_sh  <= {r_sh[30:0], 1'b0};
            r_cnt <= r_cnt + 6'd1;
         end
      end else begin
         r_busy <= 1'b0;
      end
   end

   assign o_busy = r_busy;
   assign o_last = r_busy && (r_cnt == 6'd32);
   assign o_bcd  = r_bcd;

endmodule

// File: rtl/seg_display.sv
// Memory-mapped 8-digit multiplexed seven-segment display with hex or decimal
// rendering, optional leading-zero blanking and a prescaled digit scan.
module seg_display
   import seg_pkg::*;
#(
   parameter int SCAN_DIV = 50000
)(
   input  logic        clock,
   input  logic        reset,
   input  logic        SegCtrl,
   input  logic        ioWrite,
   input  logic [15:0] write_data,
   input  logic [1:0]  segAddr,
   output logic [7:0]  seg_out,
   output logic [7:0]  seg_en,
   output logic        busy
);

   localparam int PW = $clog2(SCAN_DIV);

   logic            w_wr;
   logic            w_start;
   logic            w_wrap;
   logic            w_lit_next;
   logic [2:0]      w_idx_next;
   logic [31:0]     w_value_next;
   ctrl_t           w_ctrl_next;
   logic            w_conv_busy;
   logic            w_conv_last;
   logic [39:0]     w_bcd;
   logic [7:0][7:0] w_dec_digits;

   logic [31:0]     r_value;
   ctrl_t           r_ctrl;
   logic [7:0][7:0] r_shadow;
   logic [PW-1:0]   r_presc;
   logic [2:0]      r_idx;
   logic            r_lit;
   logic [7:0]      r_seg_out;
   logic [7:0]      r_seg_en;

   // Register-map decode; the converter is fed the post-write value so it starts on the write edge.
   always_comb begin
      w_wr         = SegCtrl && ioWrite;
      w_value_next = r_value;
      w_ctrl_next  = r_ctrl;
      if (w_wr) begin
         case (segAddr)
            ADDR_VAL_LO: w_value_next = {r_value[31:16], write_data};
            ADDR_VAL_HI: w_value_next = {write_data, r_value[15:0]};
            ADDR_CTRL: begin
               w_ctrl_next.mode     = write_data[CTRL_MODE];
               w_ctrl_next.blank_lz = write_data[CTRL_BLANK];
               w_ctrl_next.disp_en  = write_data[CTRL_DISP];
            end
            default: w_value_next = r_value;
         endcase
      end else begin
         w_value_next = r_value;
         w_ctrl_next  = r_ctrl;
      end
      w_start = w_wr && (segAddr != ADDR_IGNORED) && w_ctrl_next.mode;
   end

   // Values above 99_999_999 show up as a nonzero digit 8 or 9.
   always_comb begin
      if (|w_bcd[39:32]) begin
         w_dec_digits = {8{SEG_DASH}};
      end else begin
         w_dec_digits = fmt_digits(w_bcd[31:0], r_ctrl.blank_lz);
      end
   end

   // Scan step: the first wrap after reset lights digit 0, later wraps advance.
   always_comb begin
      w_wrap     = (r_presc == PW'(SCAN_DIV - 1));
      w_lit_next = r_lit || w_wrap;
      if (w_wrap && r_lit) begin
         w_idx_next = r_idx + 3'd1;
      end else begin
         w_idx_next = r_idx;
      end
   end

   bin2bcd_seq u_conv (
      .i_clock (clock),
      .i_reset (reset),
      .i_start (w_start),
      .i_bin   (w_value_next),
      .o_busy  (w_conv_busy),
      .o_last  (w_conv_last),
      .o_bcd   (w_bcd)
   );

   // Value and control registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_value <= 32'd0;
         r_ctrl  <= CTRL_RESET;
      end else begin
         r_value <= w_value_next;
         r_ctrl  <= w_ctrl_next;
      end
   end

   // Hex mode tracks the value a cycle late; decimal mode only loads a finished,
   // non-restarted conversion.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_shadow <= {8{SEG_ZERO}};
      end else if (!r_ctrl.mode) begin
         r_shadow <= fmt_digits(r_value, r_ctrl.blank_lz);
      end else if (w_conv_last && !w_start) begin
         r_shadow <= w_dec_digits;
      end else begin
         r_shadow <= r_shadow;
      end
   end

   // Prescaler and digit index.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_presc <= '0;
         r_idx   <= 3'd0;
         r_lit   <= 1'b0;
      end else begin
         r_presc <= w_wrap ? '0 : r_presc + PW'(1);
         r_idx   <= w_idx_next;
         r_lit   <= w_lit_next;
      end
   end

   // Output registers: enable and pattern always refer to the same digit.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_seg_out <= SEG_BLANK;
         r_seg_en  <= SEG_BLANK;
      end else if (w_lit_next) begin
         r_seg_out <= r_shadow[w_idx_next];
         r_seg_en  <= r_ctrl.disp_en ? ~(8'd1 << w_idx_next) : SEG_BLANK;
      end else begin
         r_seg_out <= SEG_BLANK;
         r_seg_en  <= SEG_BLANK;
      end
   end

   assign seg_out = r_seg_out;
   assign seg_en  = r_seg_en;
   assign busy    = w_conv_busy;

endmodule

// File: tb/tb_seg_display.sv
// Bench for seg_display: directed scenarios plus random bus traffic, every cycle
// checked against an arithmetic model of the display behaviour.
module tb_seg_display;

   localparam int SCAN_DIV = 4;
   localparam logic [7:0] PAT [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                       8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        SegCtrl = 1'b0;
   logic        ioWrite = 1'b0;
   logic [15:0] write_data = 16'd0;
   logic [1:0]  segAddr = 2'd0;
   logic [7:0]  seg_out;
   logic [7:0]  seg_en;
   logic        busy;

   int n_checks = 0;
   int n_pass   = 0;

   logic [31:0] m_val;
   logic [2:0]  m_ctrl;
   logic [63:0] m_shadow;
   logic [31:0] m_opnd;
   int          m_rem = 0;
   int          m_presc = 0;
   int          m_idx = 0;
   bit          m_lit = 1'b0;
   bit          m_valid = 1'b0;
   logic [7:0]  e_out;
   logic [7:0]  e_en;
   bit          e_busy;

   seg_display #(.SCAN_DIV(SCAN_DIV)) dut (
      .clock      (clock),
      .reset      (reset),
      .SegCtrl    (SegCtrl),
      .ioWrite    (ioWrite),
      .write_data (write_data),
      .segAddr    (segAddr),
      .seg_out    (seg_out),
      .seg_en     (seg_en),
      .busy       (busy)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, got, exp);
   endtask

   // Digit patterns from nibbles; blanking hides digits above the leading nonzero one.
   function automatic logic [63:0] render(input logic [31:0] nibs, input bit blank);
      int msd = 0;
      logic [63:0] r;
      for (int i = 0; i < 8; i++) if (nibs[i*4 +: 4] != 4'd0) msd = i;
      for (int i = 0; i < 8; i++) r[i*8 +: 8] = (blank && i > msd) ? 8'hFF : PAT[nibs[i*4 +: 4]];
      return r;
   endfunction

   function automatic logic [63:0] dec_view(input longint v, input bit blank);
      logic [31:0] nibs;
      longint t;
      if (v > 64'd99999999) return {8{8'hBF}};
      t = v;
      for (int i = 0; i < 8; i++) begin
         nibs[i*4 +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return render(nibs, blank);
   endfunction

   // Advance the model by one rising edge; expected outputs use pre-edge state.
   task automatic model_step();
      bit wr, start, wrap;
      logic [31:0] nv;
      logic [2:0] nc;
      if (reset) begin
         m_val = 32'd0; m_ctrl = 3'b100; m_shadow = {8{8'hC0}};
         m_rem = 0; m_presc = 0; m_idx = 0; m_lit = 1'b0;
         e_out = 8'hFF; e_en = 8'hFF; m_valid = 1'b1;
      end else begin
         nv = m_val; nc = m_ctrl;
         wr = SegCtrl && ioWrite;
         if (wr && segAddr == 2'b00) nv[15:0] = write_data;
         if (wr && segAddr == 2'b10) nv[31:16] = write_data;
         if (wr && segAddr == 2'b01) nc = write_data[2:0];
         start = wr && (segAddr != 2'b11) && nc[0];
         wrap = (m_presc == SCAN_DIV - 1);
         if (wrap) begin
            if (m_lit) m_idx = (m_idx + 1) % 8;
            m_lit = 1'b1;
         end
         e_out = m_lit ? m_shadow[m_idx*8 +: 8] : 8'hFF;
         e_en  = (m_lit && m_ctrl[2]) ? ~(8'd1 << m_idx) : 8'hFF;
         if (!m_ctrl[0]) m_shadow = render(m_val, m_ctrl[1]);
         else if (m_rem == 1 && !start) m_shadow = dec_view(m_opnd, m_ctrl[1]);
         if (start) begin
            m_rem = 32; m_opnd = nv;
         end else if (m_rem > 0) begin
            m_rem--;
         end
         m_val = nv; m_ctrl = nc;
         m_presc = wrap ? 0 : m_presc + 1;
      end
      e_busy = (m_rem != 0);
   endtask

   initial begin
      forever begin
         @(posedge clock);
         model_step();
         #2;
         if (m_valid) begin
            check("seg_out", seg_out, e_out);
            check("seg_en", seg_en, e_en);
            check("busy", busy, e_busy);
         end
      end
   end

   task automatic bus(input logic cs, input logic we, input logic [1:0] a, input logic [15:0] d);
      SegCtrl = cs; ioWrite = we; segAddr = a; write_data = d;
      @(negedge clock);
      SegCtrl = 1'b0; ioWrite = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic wait_digit(input int d, input string name, input logic [7:0] exp);
      bit found = 1'b0;
      logic [7:0] want;
      want = ~(8'd1 << d);
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clock);
         if (seg_en == want) found = 1'b1;
      end
      if (found) check(name, seg_out, exp);
      else check({name, "_timeout"}, seg_en, want);
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (busy && n < 100) begin
         n++;
         @(negedge clock);
      end
      check(name, busy, 32'd0);
   endtask

   initial begin
      logic [63:0] v;
      int n;
      int r;
      @(negedge clock);
      reset = 1'b0;
      check("rst_busy", busy, 32'd0);
      check("rst_seg_out", seg_out, 32'hFF);
      check("rst_seg_en", seg_en, 32'hFF);

      // hex digits after the first two wraps
      bus(1'b1, 1'b1, 2'b00, 16'h1234);
      bus(1'b1, 1'b1, 2'b10, 16'h0000);
      wait_digit(0, "hex_d0", 8'h99);
      wait_digit(1, "hex_d1", 8'hB0);

      // decimal conversion of 12345678
      bus(1'b1, 1'b1, 2'b01, 16'h0005);
      bus(1'b1, 1'b1, 2'b00, 16'h614E);
      bus(1'b1, 1'b1, 2'b10, 16'h00BC);
      n = 0;
      while (busy && n < 100) begin
         n++;
         @(negedge clock);
      end
      check("busy_len", n, 32'd32);
      wait_digit(0, "dec_d0", 8'h80);
      wait_digit(7, "dec_d7", 8'hF9);

      // overflow shows dashes
      bus(1'b1, 1'b1, 2'b00, 16'hE100);
      bus(1'b1, 1'b1, 2'b10, 16'h05F5);
      wait_idle("ovf_idle");
      wait_digit(0, "ovf_d0", 8'hBF);
      wait_digit(5, "ovf_d5", 8'hBF);

      // leading-zero blanking in hex
      bus(1'b1, 1'b1, 2'b01, 16'h0006);
      bus(1'b1, 1'b1, 2'b00, 16'h0007);
      bus(1'b1, 1'b1, 2'b10, 16'h0000);
      wait_digit(0, "blank_d0", 8'hF8);
      for (int d = 1; d < 8; d++) wait_digit(d, $sformatf("blank_d%0d", d), 8'hFF);

      // write on the same edge as a prescaler wrap
      bus(1'b1, 1'b1, 2'b01, 16'h0004);
      wait_digit(2, "pre_wrap_d2", 8'hC0);
      idle(3);
      bus(1'b1, 1'b1, 2'b00, 16'h0009);
      check("wrap_write_en", seg_en, 32'hF7);
      wait_digit(0, "wrap_write_val", 8'h90);

      // restart mid-conversion, then reset mid-restart
      bus(1'b1, 1'b1, 2'b01, 16'h0005);
      bus(1'b1, 1'b1, 2'b10, 16'h0000);
      bus(1'b1, 1'b1, 2'b00, 16'h04D2);
      idle(9);
      bus(1'b1, 1'b1, 2'b00, 16'h162E);
      idle(4);
      pulse_reset();
      check("abort_busy", busy, 32'd0);
      check("abort_seg_out", seg_out, 32'hFF);
      check("abort_seg_en", seg_en, 32'hFF);
      wait_digit(0, "abort_d0", 8'hC0);
      wait_digit(3, "abort_d3", 8'hC0);

      // random traffic
      for (int it = 0; it < 2000; it++) begin
         r = int'($urandom_range(0, 199));
         if (r < 2) begin
            bus(1'b1, 1'b1, 2'b01, {13'($urandom), ($urandom_range(0, 9) != 0), 1'($urandom), 1'($urandom)});
         end else if (r < 7) begin
            if ($urandom_range(0, 1) == 0) bus(1'b1, 1'b1, 2'b10, 16'($urandom_range(0, 16'h05F6)));
            else bus(1'b1, 1'b1, 2'($urandom), 16'($urandom));
         end else if (r < 10) begin
            bus(1'($urandom), 1'b0, 2'($urandom), 16'($urandom));
         end else if (r < 12) begin
            bus(1'b0, 1'b1, 2'($urandom), 16'($urandom));
         end else if (r == 199) begin
            pulse_reset();
         end else begin
            idle(1);
         end
      end

      // pin the model against hand-computed patterns
      v = dec_view(64'd12345678, 1'b0);
      check("model_dec_d0", v[7:0], 32'h80);
      check("model_dec_d7", v[63:56], 32'hF9);
      v = dec_view(64'd100000000, 1'b0);
      check("model_dash", v[31:0], 32'hBFBFBFBF);
      v = render(32'h00000007, 1'b1);
      check("model_blank_lo", v[31:0], 32'hFFFFFFF8);
      v = dec_view(64'd1200, 1'b1);
      check("model_dec_blank", v[31:0], 32'hF9A4C0C0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
